// File: rtl/vectored_int_ctrl.sv
// ---------------------------------------------------------------------------
// vectored_int_ctrl
//   Edge-captures NUM_IRQ device "done" lines into a pending register, masks
//   them, picks the highest-numbered eligible channel and hands it to the CPU
//   as a request + vector address. One interrupt is tracked in service through
//   an int_ack / eoi handshake.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   irq        in   [NUM_IRQ]  device done lines (0->1 raises pending)
//   irq_mask   in   [NUM_IRQ]  1 = channel may be selected
//   int_ack    in   CPU accepts request (only looked at in REQ)
//   eoi        in   CPU end-of-interrupt (only looked at in SERVICE)
//   int_req    out  request to CPU
//   int_addr   out  [32] VEC_BASE + int_id*VEC_STRIDE
//   int_id     out  [ID_W] latched winning channel
//   in_service out  high while in SERVICE
//   pending    out  [NUM_IRQ] pending register
// ---------------------------------------------------------------------------
module vectored_int_ctrl #(
    parameter int          NUM_IRQ    = 4,
    parameter int          ID_W       = 2,
    parameter logic [31:0] VEC_BASE   = 32'hFFFF_FFFC,
    parameter logic [31:0] VEC_STRIDE = 32'd1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               int_ack,
    input  logic               eoi,
    output logic               int_req,
    output logic [31:0]        int_addr,
    output logic [ID_W-1:0]    int_id,
    output logic               in_service,
    output logic [NUM_IRQ-1:0] pending
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t             r_state;
    logic [NUM_IRQ-1:0] r_irq_q;
    logic [NUM_IRQ-1:0] r_pend;
    logic [ID_W-1:0]    r_id;
    logic [31:0]        r_addr;
    logic               r_req;
    logic               r_insvc;

    logic [NUM_IRQ-1:0] w_set;
    logic [NUM_IRQ-1:0] w_clr;
    logic [NUM_IRQ-1:0] w_elig;
    logic [ID_W-1:0]    w_win;
    logic [31:0]        w_win_addr;
    logic               w_ack_req;

    assign w_set     = irq & ~r_irq_q;
    assign w_elig    = r_pend & irq_mask;
    assign w_ack_req = (r_state == REQ) && int_ack;

    // Ascending scan: the last hit is the highest eligible index.
    always_comb begin
        w_win = '0;
        for (int i = 0; i < NUM_IRQ; i++)
            if (w_elig[i]) w_win = ID_W'(i);
    end

    // Clear only the accepted channel; compared per index so an ID_W wider
    // than needed never indexes past the pending vector.
    always_comb begin
        w_clr = '0;
        for (int i = 0; i < NUM_IRQ; i++)
            w_clr[i] = w_ack_req && (r_id == ID_W'(i));
    end

    // Vector address wraps modulo 2^32.
    assign w_win_addr = VEC_BASE + 32'(w_win) * VEC_STRIDE;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_irq_q <= irq;     // a line already high is not an edge later
            r_pend  <= '0;
            r_id    <= '0;
            r_addr  <= VEC_BASE;
            r_req   <= 1'b0;
            r_insvc <= 1'b0;
        end else begin
            r_irq_q <= irq;
            // New edge wins over a same-cycle clear.
            r_pend  <= (r_pend & ~w_clr) | w_set;
            case (r_state)
                IDLE: begin
                    if (|w_elig) begin
                        r_id    <= w_win;
                        r_addr  <= w_win_addr;
                        r_req   <= 1'b1;
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    // id/addr frozen here; eoi is ignored even if high.
                    if (int_ack) begin
                        r_req   <= 1'b0;
                        r_insvc <= 1'b1;
                        r_state <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (eoi) begin
                        r_insvc <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_req   <= 1'b0;
                    r_insvc <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign int_req    = r_req;
    assign int_addr   = r_addr;
    assign int_id     = r_id;
    assign in_service = r_insvc;
    assign pending    = r_pend;

endmodule

// File: tb/tb_vectored_int_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vectored_int_ctrl
//   Instance A: default 4-channel configuration, compared every cycle against
//   a behavioural reference model, directed scenarios then random traffic.
//   Instance B: 8-channel generic configuration, directed constant checks.
// ---------------------------------------------------------------------------
module tb_vectored_int_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance A (defaults) ----------------
    logic        rst, int_ack, eoi;
    logic [3:0]  irq, irq_mask;
    logic        int_req, in_service;
    logic [31:0] int_addr;
    logic [1:0]  int_id;
    logic [3:0]  pending;

    vectored_int_ctrl dut_a (
        .clk(clk), .rst(rst), .irq(irq), .irq_mask(irq_mask),
        .int_ack(int_ack), .eoi(eoi), .int_req(int_req), .int_addr(int_addr),
        .int_id(int_id), .in_service(in_service), .pending(pending)
    );

    // ---------------- instance B (8 channels) ----------------
    logic        b_rst, b_ack, b_eoi;
    logic [7:0]  b_irq, b_mask;
    logic        b_req, b_insvc;
    logic [31:0] b_addr;
    logic [2:0]  b_id;
    logic [7:0]  b_pend;

    vectored_int_ctrl #(.NUM_IRQ(8), .ID_W(3), .VEC_BASE(32'h0000_0080),
                        .VEC_STRIDE(32'd4)) dut_b (
        .clk(clk), .rst(b_rst), .irq(b_irq), .irq_mask(b_mask),
        .int_ack(b_ack), .eoi(b_eoi), .int_req(b_req), .int_addr(b_addr),
        .int_id(b_id), .in_service(b_insvc), .pending(b_pend)
    );

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- reference model for instance A ----------------
    // phase: 0 = waiting, 1 = requesting CPU, 2 = CPU servicing
    int         m_phase;
    int         m_id;
    logic [3:0] m_pend, m_prev;

    task automatic model_step();
        logic [3:0] edges;
        logic [3:0] elig;
        if (rst) begin
            m_phase = 0; m_id = 0; m_pend = '0; m_prev = irq;
            return;
        end
        edges  = irq & ~m_prev;
        m_prev = irq;
        elig   = m_pend & irq_mask;
        if (m_phase == 0) begin
            if (elig != 0) begin
                for (int i = 3; i >= 0; i--)
                    if (elig[i]) begin m_id = i; break; end
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (int_ack) begin
                m_pend[m_id] = 1'b0;
                m_phase = 2;
            end
        end else begin
            if (eoi) m_phase = 0;
        end
        m_pend = m_pend | edges;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: model follows the same edge, then outputs are compared.
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check("a_req",   32'(int_req),    32'(m_phase == 1));
        check("a_insvc", 32'(in_service), 32'(m_phase == 2));
        check("a_id",    32'(int_id),     32'(m_id));
        check("a_addr",  int_addr,        32'hFFFF_FFFC + 32'(m_id));
        check("a_pend",  32'(pending),    32'(m_pend));
    endtask

    task automatic pulse_ack();
        int_ack = 1'b1; cyc(); int_ack = 1'b0;
    endtask

    task automatic pulse_eoi();
        eoi = 1'b1; cyc(); eoi = 1'b0;
    endtask

    initial begin
        rst = 1'b1; irq = 4'b0100; irq_mask = 4'hF; int_ack = 1'b0; eoi = 1'b0;
        b_rst = 1'b1; b_irq = '0; b_mask = 8'hFF; b_ack = 1'b0; b_eoi = 1'b0;
        m_phase = 0; m_id = 0; m_pend = '0; m_prev = '0;

        // Reset / idle: irq held high through reset is not an edge.
        cyc(); cyc();
        rst = 1'b0; b_rst = 1'b0;
        repeat (5) cyc();
        check("rst_req",  32'(int_req), 32'd0);
        check("rst_pend", 32'(pending), 32'd0);
        check("rst_addr", int_addr,     32'hFFFF_FFFC);
        check("b_rst_addr", b_addr,     32'h0000_0080);
        irq = 4'b0000;
        cyc();

        // Single request on channel 1.
        irq = 4'b0010; cyc();
        irq = 4'b0000; cyc();
        check("single_req",  32'(int_req), 32'd1);
        check("single_id",   32'(int_id),  32'd1);
        check("single_addr", int_addr,     32'hFFFF_FFFD);
        pulse_ack();
        check("single_svc",  32'(in_service), 32'd1);
        check("single_pend", 32'(pending),    32'd0);
        pulse_eoi();
        check("single_eoi",  32'(in_service), 32'd0);

        // Priority and freeze.
        irq = 4'b0101; cyc();
        irq = 4'b0000; cyc();
        check("prio_addr", int_addr, 32'hFFFF_FFFE);
        irq = 4'b1000; cyc();
        irq = 4'b0000; cyc();
        check("freeze_addr", int_addr, 32'hFFFF_FFFE);
        pulse_ack(); pulse_eoi(); cyc();
        check("next_id3", 32'(int_id), 32'd3);
        pulse_ack(); pulse_eoi(); cyc();
        check("last_id0", 32'(int_id), 32'd0);
        pulse_ack(); pulse_eoi();

        // Masking: pending retained while masked, request after unmask.
        irq_mask = 4'b0111;
        irq = 4'b1000; cyc();
        irq = 4'b0000;
        repeat (10) cyc();
        check("mask_noreq", 32'(int_req), 32'd0);
        check("mask_pend",  32'(pending), 32'h8);
        irq_mask = 4'hF;
        cyc(); cyc();
        check("unmask_req", 32'(int_req), 32'd1);
        check("unmask_id",  32'(int_id),  32'd3);
        pulse_ack(); pulse_eoi();

        // Set/clear collision on channel 2.
        irq = 4'b0100; cyc();
        irq = 4'b0000; cyc();
        irq = 4'b0100; int_ack = 1'b1; cyc();
        irq = 4'b0000; int_ack = 1'b0;
        check("coll_pend2", 32'(pending[2]), 32'd1);
        check("coll_svc",   32'(in_service), 32'd1);
        pulse_eoi(); cyc();
        check("coll_rereq", 32'(int_req), 32'd1);
        check("coll_id",    32'(int_id),  32'd2);
        // ack + eoi together in REQ: only ack honoured.
        int_ack = 1'b1; eoi = 1'b1; cyc();
        int_ack = 1'b0; eoi = 1'b0;
        check("acketc_svc", 32'(in_service), 32'd1);
        pulse_eoi();

        // Instance B: generic parameters, reset mid-SERVICE.
        b_irq = 8'h20; cyc();
        b_irq = 8'h00; cyc();
        check("b_req",  32'(b_req), 32'd1);
        check("b_id",   32'(b_id),  32'd5);
        check("b_addr", b_addr,     32'h0000_0094);
        b_ack = 1'b1; cyc(); b_ack = 1'b0;
        check("b_svc", 32'(b_insvc), 32'd1);
        b_irq = 8'h03; cyc();
        b_irq = 8'h00; b_rst = 1'b1; cyc(); b_rst = 1'b0;
        check("b_rst_svc",  32'(b_insvc), 32'd0);
        check("b_rst_req",  32'(b_req),   32'd0);
        check("b_rst_id",   32'(b_id),    32'd0);
        check("b_rst_a",    b_addr,       32'h0000_0080);
        check("b_rst_pend", 32'(b_pend),  32'd0);

        // Random traffic on instance A against the model.
        for (int n = 0; n < 600; n++) begin
            rst      = ($urandom_range(0, 63) == 0);
            irq      = irq ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
            irq_mask = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
            int_ack  = ($urandom_range(0, 2) == 0);
            eoi      = ($urandom_range(0, 2) == 0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
